// File: rtl/mem_rw_pkg.sv
// Shared types, parameter limits and the saturating counter helper for mem_rw_array.
package mem_rw_pkg;

  localparam int NR_MIN     = 1;
  localparam int NR_MAX     = 4;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Pipeline entries carry the widest supported word; narrower instances use the low bits.
  localparam int PIPE_DATA_W_MAX = 256;
  localparam int CNT_W_MAX       = 64;

  typedef struct packed {
    logic                       valid;
    logic                       err;
    logic [PIPE_DATA_W_MAX-1:0] data;
  } rd_pipe_t;

  function automatic logic [CNT_W_MAX-1:0] satAdd(input logic [CNT_W_MAX-1:0] cur,
                                                  input logic [CNT_W_MAX-1:0] inc,
                                                  input logic [CNT_W_MAX-1:0] maxVal);
    logic [CNT_W_MAX:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum > {1'b0, maxVal}) satAdd = maxVal;
    else satAdd = sum[CNT_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/mem_rw_array_rd_pipe.sv
// Read-latency shift register for one read channel; the last stage drives the channel outputs.
module mem_rw_rd_pipe
  import mem_rw_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  rd_pipe_t          i_req,
  output logic              o_valid,
  output logic              o_err,
  output logic [DATA_W-1:0] o_data
);

  rd_pipe_t r_stage [RD_LAT];
  logic     w_unusedDataHi;

  // Data only advances with a valid entry so the output word holds between pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < RD_LAT; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0].valid <= i_req.valid;
      r_stage[0].err   <= i_req.err;
      if (i_req.valid) r_stage[0].data <= i_req.data;
      for (int s = 1; s < RD_LAT; s++) begin
        r_stage[s].valid <= r_stage[s-1].valid;
        r_stage[s].err   <= r_stage[s-1].err;
        if (r_stage[s-1].valid) r_stage[s].data <= r_stage[s-1].data;
      end
    end
  end

  assign o_valid        = r_stage[RD_LAT-1].valid;
  assign o_err          = r_stage[RD_LAT-1].err;
  assign o_data         = r_stage[RD_LAT-1].data[DATA_W-1:0];
  assign w_unusedDataHi = ^r_stage[RD_LAT-1].data;

endmodule

// File: rtl/mem_rw_array.sv
// Word-addressed memory model: NR pipelined read channels, one masked write port, access counters.
// Define MEM_RW_BYPASS_EN to forward a same-edge in-range write to the reads of that index.
module mem_rw_array
  import mem_rw_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 64,
  parameter int DEPTH  = 1024,
  parameter int NR     = 1,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NR-1:0]        r_enable,
  input  logic [NR*IDX_W-1:0]  r_index,
  output logic [NR-1:0]        r_valid,
  output logic [NR*DATA_W-1:0] r_data,
  output logic [NR-1:0]        r_err,
  input  logic                 w_enable,
  input  logic [IDX_W-1:0]     w_index,
  input  logic [DATA_W-1:0]    w_data,
  input  logic [DATA_W-1:0]    w_mask,
  output logic                 w_err,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W_MAX-1:0] CNT_MAX = {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - CNT_W);

  if (NR < NR_MIN || NR > NR_MAX || RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX ||
      DATA_W > PIPE_DATA_W_MAX || CNT_W < 1 || CNT_W > CNT_W_MAX || IDX_W < ADDR_W) begin : g_badParam
    $error("mem_rw_array: illegal parameter combination (NR, RD_LAT, DATA_W, CNT_W or IDX_W)");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wErr;
  logic [CNT_W-1:0]  r_rdCount;
  logic [CNT_W-1:0]  r_wrCount;

  logic              w_wrInRange;
  logic              w_wrAccept;
  logic [ADDR_W-1:0] w_wrAddr;
  logic [DATA_W-1:0] w_wrMerged;
  logic [NR-1:0]     w_rdInRange;
  logic [NR-1:0]     w_rdAccept;

  // The whole index takes part in the compare so huge indices never alias onto low words.
  function automatic logic inRange(input logic [IDX_W-1:0] idx);
    inRange = {1'b0, idx} < (IDX_W+1)'(DEPTH);
  endfunction

  assign w_wrInRange = inRange(w_index);
  assign w_wrAccept  = w_enable && w_wrInRange;
  assign w_wrAddr    = w_index[ADDR_W-1:0];
  assign w_wrMerged  = (w_data & w_mask) | (r_mem[w_wrAddr] & ~w_mask);
  assign w_rdAccept  = r_enable & w_rdInRange;

  for (genvar k = 0; k < NR; k++) begin : g_chan
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_word;
    rd_pipe_t          w_req;

    assign w_idx          = r_index[k*IDX_W +: IDX_W];
    assign w_rdInRange[k] = inRange(w_idx);
`ifdef MEM_RW_BYPASS_EN
    assign w_word = (w_wrAccept && (w_idx == w_index)) ? w_wrMerged : r_mem[w_idx[ADDR_W-1:0]];
`else
    assign w_word = r_mem[w_idx[ADDR_W-1:0]];
`endif
    assign w_req = '{valid: r_enable[k],
                     err:   r_enable[k] && !w_rdInRange[k],
                     data:  w_rdInRange[k] ? PIPE_DATA_W_MAX'(w_word) : '0};

    mem_rw_rd_pipe #(
      .DATA_W(DATA_W),
      .RD_LAT(RD_LAT)
    ) u_rdPipe (
      .clock  (clock),
      .reset  (reset),
      .i_req  (w_req),
      .o_valid(r_valid[k]),
      .o_err  (r_err[k]),
      .o_data (r_data[k*DATA_W +: DATA_W])
    );
  end

  // The array itself has no reset; writes are simply blocked while reset is high.
  always_ff @(posedge clock) begin
    if (!reset && w_wrAccept) r_mem[w_wrAddr] <= w_wrMerged;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wErr    <= 1'b0;
      r_rdCount <= '0;
      r_wrCount <= '0;
    end else begin
      r_wErr    <= w_enable && !w_wrInRange;
      r_rdCount <= CNT_W'(satAdd(CNT_W_MAX'(r_rdCount), CNT_W_MAX'($countones(w_rdAccept)), CNT_MAX));
      if (w_wrAccept) r_wrCount <= CNT_W'(satAdd(CNT_W_MAX'(r_wrCount), CNT_W_MAX'(1), CNT_MAX));
    end
  end

  assign w_err    = r_wErr;
  assign rd_count = r_rdCount;
  assign wr_count = r_wrCount;

endmodule

// File: tb/tb_mem_rw_array.sv
// Directed self-checking bench for mem_rw_array: instance A (NR=2, RD_LAT=3, CNT_W=4) and
// instance B (NR=2, RD_LAT=2, CNT_W=32) for the reset-during-flight case.
module tb_mem_rw_array;

  logic clock;
  logic resetA, resetB;

  logic [1:0]   aREn;
  logic [127:0] aRIdx;
  logic [1:0]   aRValid;
  logic [127:0] aRData;
  logic [1:0]   aRErr;
  logic         aWEn;
  logic [63:0]  aWIdx, aWData, aWMask;
  logic         aWErr;
  logic [3:0]   aRdCount, aWrCount;

  logic [1:0]   bREn;
  logic [127:0] bRIdx;
  logic [1:0]   bRValid;
  logic [127:0] bRData;
  logic [1:0]   bRErr;
  logic         bWEn;
  logic [63:0]  bWIdx, bWData, bWMask;
  logic         bWErr;
  logic [31:0]  bRdCount, bWrCount;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES = {64{1'b1}};

  mem_rw_array #(.DATA_W(64), .IDX_W(64), .DEPTH(1024), .NR(2), .RD_LAT(3), .CNT_W(4)) u_dutA (
    .clock(clock), .reset(resetA),
    .r_enable(aREn), .r_index(aRIdx), .r_valid(aRValid), .r_data(aRData), .r_err(aRErr),
    .w_enable(aWEn), .w_index(aWIdx), .w_data(aWData), .w_mask(aWMask), .w_err(aWErr),
    .rd_count(aRdCount), .wr_count(aWrCount)
  );

  mem_rw_array #(.DATA_W(64), .IDX_W(64), .DEPTH(1024), .NR(2), .RD_LAT(2), .CNT_W(32)) u_dutB (
    .clock(clock), .reset(resetB),
    .r_enable(bREn), .r_index(bRIdx), .r_valid(bRValid), .r_data(bRData), .r_err(bRErr),
    .w_enable(bWEn), .w_index(bWIdx), .w_data(bWData), .w_mask(bWMask), .w_err(bWErr),
    .rd_count(bRdCount), .wr_count(bWrCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every step lands 1 time unit after a rising edge, away from the sampling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of requests into instance A, then returns its enables to idle.
  task automatic applyStimulus(input logic [1:0] rEn, input logic [63:0] rIdx0, input logic [63:0] rIdx1,
                               input logic wEn, input logic [63:0] wIdx, input logic [63:0] wData,
                               input logic [63:0] wMask);
    aREn   = rEn;
    aRIdx  = {rIdx1, rIdx0};
    aWEn   = wEn;
    aWIdx  = wIdx;
    aWData = wData;
    aWMask = wMask;
    tick();
    aREn = 2'b00;
    aWEn = 1'b0;
  endtask

  task automatic writeA(input logic [63:0] idx, input logic [63:0] data, input logic [63:0] mask);
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b1, idx, data, mask);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] expSameEdge;
`ifdef MEM_RW_BYPASS_EN
    expSameEdge = 64'h1;
`else
    expSameEdge = 64'h2;
`endif
    resetA = 1'b1; resetB = 1'b1;
    aREn = '0; aRIdx = '0; aWEn = 1'b0; aWIdx = '0; aWData = '0; aWMask = '0;
    bREn = '0; bRIdx = '0; bWEn = 1'b0; bWIdx = '0; bWData = '0; bWMask = '0;
    tick();
    tick();

    checkOutput("rst A r_valid",  64'(aRValid),  64'd0);
    checkOutput("rst A r_data",   aRData[63:0] | aRData[127:64], 64'd0);
    checkOutput("rst A r_err",    64'(aRErr),    64'd0);
    checkOutput("rst A w_err",    64'(aWErr),    64'd0);
    checkOutput("rst A rd_count", 64'(aRdCount), 64'd0);
    checkOutput("rst A wr_count", 64'(aWrCount), 64'd0);
    checkOutput("rst B r_valid",  64'(bRValid),  64'd0);
    checkOutput("rst B w_err",    64'(bWErr),    64'd0);
    resetA = 1'b0; resetB = 1'b0;

    // Test 1: full-mask write then read at latency 3.
    writeA(64'd5, 64'hDEAD_BEEF_0000_1111, ONES);
    applyStimulus(2'b01, 64'd5, 64'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    tick();
    checkOutput("t1 not early",   64'(aRValid), 64'd0);
    tick();
    checkOutput("t1 r_valid",     64'(aRValid), 64'b01);
    checkOutput("t1 r_data",      aRData[63:0], 64'hDEAD_BEEF_0000_1111);
    checkOutput("t1 r_err",       64'(aRErr),   64'd0);
    checkOutput("t1 rd_count",    64'(aRdCount), 64'd1);
    checkOutput("t1 wr_count",    64'(aWrCount), 64'd1);
    tick();
    checkOutput("t1 pulse ends",  64'(aRValid), 64'd0);
    checkOutput("t1 data holds",  aRData[63:0], 64'hDEAD_BEEF_0000_1111);

    // Test 2: masked write over zero, read on channel 1; then a mask-0 write still counts.
    writeA(64'd7, 64'd0, ONES);
    writeA(64'd7, ONES, 64'h0000_0000_FFFF_0000);
    applyStimulus(2'b10, 64'd0, 64'd7, 1'b0, 64'd0, 64'd0, 64'd0);
    tick();
    tick();
    checkOutput("t2 r_valid",     64'(aRValid), 64'b10);
    checkOutput("t2 r_data ch1",  aRData[127:64], 64'h0000_0000_FFFF_0000);
    writeA(64'd7, ONES, 64'd0);
    checkOutput("t2 wr_count",    64'(aWrCount), 64'd4);

    // Test 3: read-during-write on both channels, then the new word afterwards.
    writeA(64'd9, 64'h2, ONES);
    applyStimulus(2'b11, 64'd9, 64'd9, 1'b1, 64'd9, 64'h1, ONES);
    tick();
    tick();
    checkOutput("t3 r_valid",     64'(aRValid), 64'b11);
    checkOutput("t3 same-edge ch0", aRData[63:0],   expSameEdge);
    checkOutput("t3 same-edge ch1", aRData[127:64], expSameEdge);
    applyStimulus(2'b01, 64'd9, 64'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    tick();
    tick();
    checkOutput("t3 after write", aRData[63:0], 64'h1);

    // Test 4: out-of-range read and write; idx 0 must not be hit by a truncated index.
    writeA(64'd0, 64'hA5A5, ONES);
    applyStimulus(2'b01, 64'd1024, 64'd0, 1'b1, 64'h1_0000_0000, ONES, ONES);
    checkOutput("t4 w_err pulse", 64'(aWErr), 64'd1);
    tick();
    checkOutput("t4 w_err clears", 64'(aWErr), 64'd0);
    checkOutput("t4 early",       64'(aRValid), 64'd0);
    tick();
    checkOutput("t4 r_valid",     64'(aRValid), 64'b01);
    checkOutput("t4 r_err",       64'(aRErr),   64'b01);
    checkOutput("t4 r_data zero", aRData[63:0], 64'd0);
    checkOutput("t4 rd_count",    64'(aRdCount), 64'd5);
    checkOutput("t4 wr_count",    64'(aWrCount), 64'd7);
    applyStimulus(2'b01, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 64'd0);
    tick();
    tick();
    checkOutput("t4 idx0 intact", aRData[63:0], 64'hA5A5);
    checkOutput("t4 idx0 r_err",  64'(aRErr),   64'd0);
    checkOutput("t4 rd_count2",   64'(aRdCount), 64'd6);

    // Test 6: 20 more writes saturate the 4-bit write counter at 15.
    for (int i = 0; i < 7; i++) writeA(64'd10, 64'(i), ONES);
    checkOutput("t6 wr_count 14", 64'(aWrCount), 64'd14);
    for (int i = 0; i < 13; i++) writeA(64'd10, 64'(i), ONES);
    checkOutput("t6 wr_count sat", 64'(aWrCount), 64'd15);

    // Test 5 on instance B: reset lands right after a dual-channel issue.
    bWEn = 1'b1; bWMask = ONES;
    bWIdx = 64'd3; bWData = 64'h1234;
    tick();
    bWIdx = 64'd4; bWData = 64'h5678;
    tick();
    bWEn = 1'b0;
    bREn = 2'b11; bRIdx = {64'd4, 64'd3};
    tick();
    resetB = 1'b1;
    bWEn = 1'b1; bWIdx = 64'd3; bWData = 64'hFFFF;
    #1;
    checkOutput("t5 rst r_valid", 64'(bRValid), 64'd0);
    checkOutput("t5 rst r_data",  bRData[63:0] | bRData[127:64], 64'd0);
    tick();
    tick();
    resetB = 1'b0;
    bREn = 2'b00; bWEn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t5 no stale valid %0d", i), 64'(bRValid), 64'd0);
    end
    checkOutput("t5 rd_count",    64'(bRdCount), 64'd0);
    checkOutput("t5 wr_count",    64'(bWrCount), 64'd0);
    bREn = 2'b11; bRIdx = {64'd4, 64'd3};
    tick();
    bREn = 2'b00;
    checkOutput("t5 post early",  64'(bRValid), 64'd0);
    tick();
    checkOutput("t5 post r_valid", 64'(bRValid), 64'b11);
    checkOutput("t5 post ch0",    bRData[63:0],   64'h1234);
    checkOutput("t5 post ch1",    bRData[127:64], 64'h5678);
    checkOutput("t5 post rd_count", 64'(bRdCount), 64'd2);
    checkOutput("t5 post r_err",  64'(bRErr),    64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
